canny_hysteresis_stream: RTL and testbench
==========================================

// Module: canny_hysteresis_stream
// PURPOSE
// Final Canny stage: classifies raw gradient magnitudes against runtime thresholds and applies
// one-pass hysteresis over a 3x3 window built from internal line buffers.
// Weak pixels are promoted only if a strong neighbour exists.
// Replaces the pre-thresholded 3-row fixed-width checker: frame-aware, border-correct,
// configurable connectivity, and it self-flushes the last line.
// PARAMETERS
// WIDTH       8    pixel/magnitude bit width; edge output value = {WIDTH{1'b1}}
// IMG_WIDTH   250  pixels per line (>=3)
// IMG_HEIGHT  250  lines per frame (>=2)
// CONNECT     8    neighbourhood: 8 = full 3x3, 4 = N/S/E/W only
// PORTS
// clk        in   1      clock
// rst        in   1      synchronous, active-high reset
// din_valid  in   1      input beat valid; accepted when din_valid & din_ready
// din_sof    in   1      qualifies first pixel of frame; latches thresholds
// din        in   WIDTH  gradient magnitude, raster order
// thr_hi     in   WIDTH  strong threshold, sampled on accepted SOF beat
// thr_lo     in   WIDTH  weak threshold, sampled on accepted SOF beat
// din_ready  out  1      low only during FLUSH
// dout_valid out  1      output pixel valid (no downstream backpressure)
// dout_sof   out  1      first output pixel of frame
// dout_eol   out  1      last pixel of each output line
// dout       out  WIDTH  0 or {WIDTH{1'b1}}
// BEHAVIOUR
// - One clock; reset is synchronous and active-high. Reset: state=IDLE, din_ready=1, dout_valid=0,
//   dout_sof=0, dout_eol=0, dout=0, counters=0. Line-buffer RAM is not cleared.
//   Border masking makes cleared RAM unnecessary.
// - Class per input: STRONG if din>=thr_hi; WEAK if thr_lo<=din<thr_hi; NONE otherwise.
//   If thr_lo>thr_hi, WEAK never occurs. Stored as 2 bits in two line buffers (2 x IMG_WIDTH).
// - Output rule for centre pixel: STRONG -> max. WEAK with >=1 STRONG neighbour
//   (8- or 4-connected per CONNECT) -> max. Else 0. Single pass, no iterative tracing.
// - Neighbours outside the image (row -1/IMG_HEIGHT, col -1/IMG_WIDTH) count as NONE.
//   No wrap-around between lines.
// - Latency: D = IMG_WIDTH+1 beats. Output pixel k (raster index) is registered the cycle after
//   input beat k+D is accepted. Input gaps (din_valid=0) freeze the pipeline; dout_valid=0 then.
// - FSM:
//   - IDLE: accepts a beat only with din_sof; a non-SOF beat is dropped. SOF -> RUN.
//   - RUN: counts col/row. After the last pixel (row=IMG_HEIGHT-1, col=IMG_WIDTH-1) is accepted -> FLUSH.
//   - FLUSH: din_ready=0. Emits the remaining D pixels, one per clock, with bottom border padding.
//     Then returns to IDLE.
// - SOF accepted in RUN (short frame): restart. Counters zeroed, thresholds relatched,
//   undelivered outputs of the old frame discarded. No dout_sof until pixel 0 of the new frame.
// - dout_sof asserted with output pixel 0. dout_eol asserted at output col IMG_WIDTH-1.
//   Exactly IMG_WIDTH*IMG_HEIGHT outputs per complete frame.
// - Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). All compares unsigned.
// - rst mid-frame: immediate return to reset state; partial frame lost.
// TESTING
// - 4x3 frame (IMG_WIDTH=4,IMG_HEIGHT=3), thr_hi=200, thr_lo=100, all din=50
//   -> 12 outputs all 0; sof on 1st, eol on 4th/8th/12th.
// - Same frame, centre (1,1)=150, (0,0)=220, rest 0. CONNECT=8 -> out(1,1)=255, out(0,0)=255.
//   CONNECT=4 -> out(1,1)=0.
// - Weak at (0,3), strong at (1,0) -> out(0,3)=0; confirms no line wrap-around.
// - din_valid toggled 1/0 every cycle
//   -> identical output values/order, dout_valid only on cycles following accepted beats.
// - FLUSH: din_valid held high after last pixel -> din_ready=0 for exactly 5 cycles (D=5),
//   5 trailing outputs, then din_ready=1.
// - SOF injected at pixel 6 of frame, with thr_hi=10 -> old outputs stop.
//   New frame thresholds 10/5 applied from its pixel 0. rst pulse mid-run -> dout_valid=0 next cycle.

Source files
------------

// File: rtl/canny_hysteresis_stream.sv
// Final Canny stage: threshold classification plus single-pass 3x3 hysteresis on a raster stream.
// Two class line buffers feed a 3x3 window; the output lags the input by IMG_WIDTH+1 beats.
module canny_hysteresis_stream #(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 250,
  parameter int IMG_HEIGHT = 250,
  parameter int CONNECT    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din_sof,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic             din_ready,
  output logic             dout_valid,
  output logic             dout_sof,
  output logic             dout_eol,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  localparam logic [1:0] C_NONE   = 2'b00;
  localparam logic [1:0] C_WEAK   = 2'b01;
  localparam logic [1:0] C_STRONG = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  function automatic logic [1:0] classify(input logic [WIDTH-1:0] mag,
                                          input logic [WIDTH-1:0] hi,
                                          input logic [WIDTH-1:0] lo);
    logic [1:0] c;
    c = C_NONE;
    if (mag >= hi)      c = C_STRONG;
    else if (mag >= lo) c = C_WEAK;
    return c;
  endfunction

  function automatic logic is_strong(input logic [1:0] c);
    return c == C_STRONG;
  endfunction

  state_t state, state_nxt;

  logic [WIDTH-1:0] thr_hi_q, thr_lo_q;
  logic [CW-1:0]    in_col, out_col;
  logic [RW-1:0]    in_row, out_row;
  logic             out_act;

  logic [1:0] lb1 [IMG_WIDTH];
  logic [1:0] lb2 [IMG_WIDTH];
  logic [1:0] win_p1 [3];
  logic [1:0] win_p2 [3];

  logic             acc, restart, take, flushing, adv;
  logic [CW-1:0]    col_p0;
  logic [RW-1:0]    row_p0;
  logic [WIDTH-1:0] hi_eff, lo_eff;
  logic [1:0]       cls_p0, top_p0, mid_p0;
  logic             vld_p0, last_in, last_out;
  logic             has_up, has_dn, has_lf, has_rt;
  logic             s_tl, s_t, s_tr, s_l, s_r, s_bl, s_b, s_br;
  logic             nb_strong, edge_p0;

  // Stage p0: beat acceptance, classification and line-buffer read
  assign din_ready = (state != S_FLUSH);
  assign acc       = din_valid & din_ready;
  assign restart   = acc & din_sof;
  assign take      = acc & (din_sof | (state == S_RUN));
  assign flushing  = (state == S_FLUSH);
  assign adv       = take | flushing;

  assign col_p0 = restart ? '0 : in_col;
  assign row_p0 = restart ? '0 : in_row;
  assign hi_eff = restart ? thr_hi : thr_hi_q;
  assign lo_eff = restart ? thr_lo : thr_lo_q;

  // Flush beats are virtual pixels below the frame; their class is forced to NONE.
  assign cls_p0 = flushing ? C_NONE : classify(din, hi_eff, lo_eff);
  assign top_p0 = lb2[col_p0];
  assign mid_p0 = lb1[col_p0];

  // The first output appears once the bottom-right neighbour of pixel 0, at (1,1), arrives.
  assign vld_p0   = adv & ((out_act & ~restart) | (row_p0 == ROW_ONE && col_p0 == COL_ONE));
  assign last_in  = (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);
  assign last_out = (out_row == ROW_LAST) && (out_col == COL_LAST);

  // Stale window/RAM contents only ever land in positions these masks remove.
  assign has_up = (out_row != '0);
  assign has_dn = (out_row != ROW_LAST);
  assign has_lf = (out_col != '0);
  assign has_rt = (out_col != COL_LAST);

  assign s_tl = is_strong(win_p2[0]) & has_up & has_lf;
  assign s_t  = is_strong(win_p1[0]) & has_up;
  assign s_tr = is_strong(top_p0)    & has_up & has_rt;
  assign s_l  = is_strong(win_p2[1]) & has_lf;
  assign s_r  = is_strong(mid_p0)    & has_rt;
  assign s_bl = is_strong(win_p2[2]) & has_dn & has_lf;
  assign s_b  = is_strong(win_p1[2]) & has_dn;
  assign s_br = is_strong(cls_p0)    & has_dn & has_rt;

  assign nb_strong = (CONNECT == 4) ? (s_t | s_l | s_r | s_b)
                                    : (s_tl | s_t | s_tr | s_l | s_r | s_bl | s_b | s_br);
  assign edge_p0   = (win_p1[1] == C_STRONG) || ((win_p1[1] == C_WEAK) && nb_strong);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (restart) state_nxt = S_RUN;
      S_RUN:   if (restart) state_nxt = S_RUN;
               else if (take && last_in) state_nxt = S_FLUSH;
      S_FLUSH: if (vld_p0 && last_out) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Stage p1: counters and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      in_col     <= '0;
      in_row     <= '0;
      out_col    <= '0;
      out_row    <= '0;
      out_act    <= 1'b0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eol   <= 1'b0;
      dout       <= '0;
    end else begin
      if (adv) begin
        in_col <= (col_p0 == COL_LAST) ? '0 : col_p0 + COL_ONE;
        if (take) begin
          if (col_p0 != COL_LAST) in_row <= row_p0;
          else if (last_in)       in_row <= '0;
          else                    in_row <= row_p0 + ROW_ONE;
        end
      end
      if (restart) begin
        out_act <= 1'b0;
        out_col <= '0;
        out_row <= '0;
      end else if (vld_p0) begin
        out_act <= ~last_out;
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= last_out ? '0 : out_row + ROW_ONE;
        end else begin
          out_col <= out_col + COL_ONE;
        end
      end
      dout_valid <= vld_p0;
      dout_sof   <= vld_p0 && (out_row == '0) && (out_col == '0);
      dout_eol   <= vld_p0 && (out_col == COL_LAST);
      if (vld_p0) dout <= edge_p0 ? {WIDTH{1'b1}} : '0;
    end
  end

  // Data path: thresholds, line buffers and window carry no reset
  always_ff @(posedge clk) begin
    if (restart) begin
      thr_hi_q <= thr_hi;
      thr_lo_q <= thr_lo;
    end
    if (take) begin
      lb1[col_p0] <= cls_p0;
      lb2[col_p0] <= mid_p0;
    end
    if (adv) begin
      win_p2    <= win_p1;
      win_p1[0] <= top_p0;
      win_p1[1] <= mid_p0;
      win_p1[2] <= cls_p0;
    end
  end

endmodule

// File: tb/tb_canny_hysteresis_stream.sv
// Bench for canny_hysteresis_stream on a 4x3 frame, with 8- and 4-connected instances side by side.
module tb_canny_hysteresis_stream;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  localparam int D = W + 1;

  logic clk = 1'b0;
  logic rst, din_valid, din_sof;
  logic [7:0] din, thr_hi, thr_lo;
  logic rdy8, vld8, sof8, eol8, rdy4, vld4, sof4, eol4;
  logic [7:0] d8, d4;

  always #5 clk = ~clk;

  canny_hysteresis_stream #(.WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CONNECT(8)) u8 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof), .din(din),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .din_ready(rdy8), .dout_valid(vld8),
    .dout_sof(sof8), .dout_eol(eol8), .dout(d8));

  canny_hysteresis_stream #(.WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CONNECT(4)) u4 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_sof(din_sof), .din(din),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .din_ready(rdy4), .dout_valid(vld4),
    .dout_sof(sof4), .dout_eol(eol4), .dout(d4));

  // Output code: value*4 + sof*2 + eol
  int q8[$];
  int q4[$];
  int total = 0;
  int bad = 0;
  int orphan = 0;
  logic prev_acc = 1'b0;
  logic prev_rdy = 1'b0;

  always @(posedge clk) begin
    prev_acc <= din_valid & rdy8;
    prev_rdy <= rdy8;
  end

  always @(negedge clk) begin
    if (vld8 === 1'b1) q8.push_back(int'(d8) * 4 + int'(sof8) * 2 + int'(eol8));
    if (vld4 === 1'b1) q4.push_back(int'(d4) * 4 + int'(sof4) * 2 + int'(eol4));
    if (vld8 === 1'b1 && prev_rdy === 1'b1 && prev_acc === 1'b0) orphan++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int mpix[N];
  int exp8[N];
  int exp4[N];

  function automatic int cls(int v, int hi, int lo);
    if (v >= hi) return 2;
    if (v >= lo) return 1;
    return 0;
  endfunction

  function automatic int flags(int k);
    return ((k == 0) ? 2 : 0) + (((k % W) == W - 1) ? 1 : 0);
  endfunction

  function automatic void run_model(int hi, int lo);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int k;
        bit e8, e4;
        k = r * W + c;
        e8 = (cls(mpix[k], hi, lo) == 2);
        e4 = e8;
        if (cls(mpix[k], hi, lo) == 1) begin
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              int rr, cc;
              rr = r + dr;
              cc = c + dc;
              if ((dr != 0 || dc != 0) && rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                if (cls(mpix[rr * W + cc], hi, lo) == 2) begin
                  e8 = 1'b1;
                  if (dr == 0 || dc == 0) e4 = 1'b1;
                end
              end
            end
          end
        end
        exp8[k] = (e8 ? 255 : 0) * 4 + flags(k);
        exp4[k] = (e4 ? 255 : 0) * 4 + flags(k);
      end
    end
  endfunction

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic idle_cycle();
    din_valid = 1'b0;
    din_sof   = 1'b0;
    din       = 8'($urandom_range(0, 255));
    @(posedge clk);
    #1;
  endtask

  task automatic put_beat(bit sof, int data, int hi, int lo);
    din_valid = 1'b1;
    din_sof   = sof;
    din       = 8'(data);
    thr_hi    = sof ? 8'(hi) : 8'($urandom_range(0, 255));
    thr_lo    = sof ? 8'(lo) : 8'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_sof   = 1'b0;
  endtask

  // gmode: 0 back-to-back, 1 alternate valid/idle, 2 random gaps
  task automatic send_frame(int hi, int lo, int gmode, bit hold);
    int sz, n;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        n = (gmode == 1) ? 1 : (gmode == 2) ? $urandom_range(0, 2) : 0;
        repeat (n) idle_cycle();
      end
      put_beat(k == 0, mpix[k], hi, lo);
    end
    if (hold) begin
      din_valid = 1'b1;
      @(negedge clk);
      #1;
      sz = q8.size();
      n = 0;
      while (rdy8 !== 1'b1 && n < 50) begin
        n++;
        @(negedge clk);
        #1;
      end
      chk("flush ready-low cycles", n, D);
      chk("flush trailing outputs", N - sz, D);
      @(posedge clk);
      #1;
      din_valid = 1'b0;
    end
  endtask

  task automatic check_frame(string tag, int off);
    int t;
    t = 0;
    while ((q8.size() < off + N || q4.size() < off + N) && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk($sformatf("%s count c8", tag), q8.size(), off + N);
    chk($sformatf("%s count c4", tag), q4.size(), off + N);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s c8 px%0d code", tag, k), (off + k < q8.size()) ? q8[off + k] : -1, exp8[k]);
      chk($sformatf("%s c4 px%0d code", tag, k), (off + k < q4.size()) ? q4[off + k] : -1, exp4[k]);
    end
  endtask

  typedef struct packed {
    logic [N*8-1:0] pix;
    logic [7:0]     hi;
    logic [7:0]     lo;
    logic [N-1:0]   m8;
    logic [N-1:0]   m4;
    logic [1:0]     gmode;
    logic           hold;
  } vec_t;

  vec_t tbl[7];

  initial begin
    for (int i = 0; i < 7; i++) begin
      tbl[i] = '0;
      tbl[i].hi = 8'd200;
      tbl[i].lo = 8'd100;
    end
    // all below the weak threshold; also exercises flush with valid held high
    tbl[0].pix = {N{8'd50}};
    tbl[0].hold = 1'b1;
    // weak centre diagonal to a strong corner, valid toggling every cycle
    tbl[1].pix[0*8 +: 8] = 8'd220;
    tbl[1].pix[5*8 +: 8] = 8'd150;
    tbl[1].m8 = 12'h021;
    tbl[1].m4 = 12'h001;
    tbl[1].gmode = 2'd1;
    // weak at line end, strong at start of next line: no wrap
    tbl[2].pix[3*8 +: 8] = 8'd150;
    tbl[2].pix[4*8 +: 8] = 8'd220;
    tbl[2].m8 = 12'h010;
    tbl[2].m4 = 12'h010;
    tbl[2].gmode = 2'd2;
    tbl[3].pix[1*8 +: 8] = 8'd250;
    tbl[3].pix[6*8 +: 8] = 8'd150;
    tbl[3].m8 = 12'h042;
    tbl[3].m4 = 12'h002;
    // weak on the bottom row below a strong pixel
    tbl[4].pix[4*8 +: 8] = 8'd200;
    tbl[4].pix[8*8 +: 8] = 8'd120;
    tbl[4].m8 = 12'h110;
    tbl[4].m4 = 12'h110;
    // thr_lo above thr_hi: no weak class at all
    tbl[5].hi = 8'd100;
    tbl[5].lo = 8'd150;
    tbl[5].pix[1*8 +: 8] = 8'd140;
    tbl[5].pix[2*8 +: 8] = 8'd99;
    tbl[5].m8 = 12'h002;
    tbl[5].m4 = 12'h002;
    // exact threshold values
    tbl[6].pix[5*8 +: 8]  = 8'd100;
    tbl[6].pix[6*8 +: 8]  = 8'd99;
    tbl[6].pix[10*8 +: 8] = 8'd200;
    tbl[6].m8 = 12'h420;
    tbl[6].m4 = 12'h400;

    rst = 1'b1;
    din_valid = 1'b0;
    din_sof = 1'b0;
    din = '0;
    thr_hi = '0;
    thr_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset din_ready", int'(rdy8), 1);
    chk("reset dout_valid", int'(vld8), 0);
    chk("reset dout_sof", int'(sof8), 0);
    chk("reset dout_eol", int'(eol8), 0);
    chk("reset dout", int'(d8), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // a non-SOF beat in IDLE is dropped
    put_beat(1'b0, 255, 0, 0);
    repeat (2) idle_cycle();

    for (int i = 0; i < 7; i++) begin
      q8.delete();
      q4.delete();
      for (int k = 0; k < N; k++) begin
        mpix[k] = int'(tbl[i].pix[k*8 +: 8]);
        exp8[k] = (tbl[i].m8[k] ? 255 : 0) * 4 + flags(k);
        exp4[k] = (tbl[i].m4[k] ? 255 : 0) * 4 + flags(k);
      end
      send_frame(int'(tbl[i].hi), int'(tbl[i].lo), int'(tbl[i].gmode), tbl[i].hold);
      check_frame($sformatf("vec%0d", i), 0);
    end

    for (int f = 0; f < 8; f++) begin
      int hi, lo;
      q8.delete();
      q4.delete();
      hi = $urandom_range(80, 220);
      lo = $urandom_range(30, 200);
      for (int k = 0; k < N; k++) mpix[k] = $urandom_range(0, 255);
      run_model(hi, lo);
      send_frame(hi, lo, 2, f[0]);
      check_frame($sformatf("rand%0d", f), 0);
    end

    // SOF at beat 6 restarts: only old pixel 0 was delivered
    q8.delete();
    q4.delete();
    put_beat(1'b1, 220, 200, 100);
    for (int k = 1; k < 6; k++) put_beat(1'b0, 0, 0, 0);
    for (int k = 0; k < N; k++) mpix[k] = $urandom_range(0, 15);
    run_model(10, 5);
    send_frame(10, 5, 0, 1'b0);
    chk("restart old pixel0 c8", (q8.size() > 0) ? q8[0] : -1, 255 * 4 + 2);
    chk("restart old pixel0 c4", (q4.size() > 0) ? q4[0] : -1, 255 * 4 + 2);
    check_frame("restart", 1);

    // reset in the middle of a frame, with a beat offered on the reset edge
    put_beat(1'b1, $urandom_range(0, 255), 120, 60);
    for (int k = 1; k < 6; k++) put_beat(1'b0, $urandom_range(0, 255), 0, 0);
    din_valid = 1'b1;
    din = 8'd255;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-run rst dout_valid", int'(vld8), 0);
    chk("mid-run rst din_ready", int'(rdy8), 1);
    chk("mid-run rst dout", int'(d8), 0);
    rst = 1'b0;
    din_valid = 1'b0;
    repeat (2) idle_cycle();
    q8.delete();
    q4.delete();
    for (int k = 0; k < N; k++) mpix[k] = $urandom_range(0, 255);
    run_model(150, 70);
    send_frame(150, 70, 1, 1'b1);
    check_frame("after rst", 0);

    chk("dout_valid without accepted beat", orphan, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
